// File: rtl/mb_shift_reg.sv
// Shift/load register with frame counter; optional serial CRC in MODE=10 when MB_SHIFT_REG_CRC_EN is defined.
// Latency: one cycle from inputs to Q/CNT/DONE; SO is combinational from Q and MODE.
// Backpressure: EN=0 stalls the register and counter, and DONE is forced low.
module mb_shift_reg #(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT = '0,
  parameter logic [WIDTH-1:0] POLY = WIDTH'(8'h07)
) (
  input  logic                       CLK,
  input  logic                       CLR,
  input  logic                       EN,
  input  logic [1:0]                 MODE,
  input  logic [WIDTH-1:0]           D,
  input  logic                       SI,
  output logic [WIDTH-1:0]           Q,
  output logic                       SO,
  output logic [$clog2(WIDTH+1)-1:0] CNT,
  output logic                       DONE
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_MSB  = 2'b10;
  localparam logic [1:0] MODE_LSB  = 2'b11;

  logic [WIDTH-1:0] shift_msb;
  logic [WIDTH-1:0] shift_lsb;

`ifdef MB_SHIFT_REG_CRC_EN
  logic fb;

  always_comb begin
    fb        = Q[WIDTH-1] ^ SI;
    shift_msb = {Q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
  end
`else
  // Keeps POLY referenced without generating any logic in the plain build.
  logic unused_poly;
  assign unused_poly = ^POLY;

  always_comb begin
    shift_msb = {Q[WIDTH-2:0], SI};
  end
`endif

  assign shift_lsb = {SI, Q[WIDTH-1:1]};

  always_comb begin
    case (MODE)
      MODE_MSB: SO = Q[WIDTH-1];
      MODE_LSB: SO = Q[0];
      default:  SO = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      Q    <= INIT;
      CNT  <= '0;
      DONE <= 1'b0;
    end else if (!EN) begin
      DONE <= 1'b0;
    end else begin
      case (MODE)
        MODE_HOLD: begin
          DONE <= 1'b0;
        end
        MODE_LOAD: begin
          Q    <= D;
          CNT  <= '0;
          DONE <= 1'b0;
        end
        default: begin
          Q <= (MODE == MODE_MSB) ? shift_msb : shift_lsb;
          // Direction changes share one counter; the frame ends after WIDTH shifts of any mix.
          if (CNT == LAST) begin
            CNT  <= '0;
            DONE <= 1'b1;
          end else begin
            CNT  <= CNT + 1'b1;
            DONE <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mb_shift_reg.sv
// Directed bench for mb_shift_reg at WIDTH=8, INIT=0, POLY=8'h07.
module tb_mb_shift_reg;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       EN;
  logic [1:0] MODE;
  logic [7:0] D;
  logic       SI;
  logic [7:0] Q;
  logic       SO;
  logic [3:0] CNT;
  logic       DONE;

  int n_cmp = 0;
  int n_err = 0;

  mb_shift_reg #(.WIDTH(8), .INIT(8'h00), .POLY(8'h07)) dut (
    .CLK(CLK), .CLR(CLR), .EN(EN), .MODE(MODE), .D(D), .SI(SI),
    .Q(Q), .SO(SO), .CNT(CNT), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic set_in(input logic clr, input logic en, input logic [1:0] mode,
                        input logic [7:0] d, input logic si);
    CLR = clr; EN = en; MODE = mode; D = d; SI = si;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic cyc(input logic clr, input logic en, input logic [1:0] mode,
                     input logic [7:0] d, input logic si);
    set_in(clr, en, mode, d, si);
    tick();
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b0, 2'b01, 8'hFF, 1'b1);
    n_cmp++; if (Q !== 8'h00) begin n_err++; $display("FAIL reset_q got %h want 00", Q); end
    n_cmp++; if (CNT !== 4'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", CNT); end
    n_cmp++; if (DONE !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", DONE); end
    n_cmp++; if (SO !== 1'b0) begin n_err++; $display("FAIL reset_so_load got %b want 0", SO); end
  endtask

  task automatic test_msb_shift();
    logic [7:0] so_pat;
    logic [7:0] qm;
    int pulses;
    so_pat = 8'hA5;
    qm     = 8'hA5;
    pulses = 0;
    cyc(1'b0, 1'b1, 2'b01, 8'hA5, 1'b0);
    n_cmp++; if (Q !== 8'hA5) begin n_err++; $display("FAIL msb_load got %h want a5", Q); end
    for (int i = 0; i < 8; i++) begin
      set_in(1'b0, 1'b1, 2'b10, 8'h00, 1'b0);
`ifdef MB_SHIFT_REG_CRC_EN
      n_cmp++; if (SO !== qm[7]) begin n_err++; $display("FAIL msb_so[%0d] got %b want %b", i, SO, qm[7]); end
      qm = {qm[6:0], 1'b0} ^ (qm[7] ? 8'h07 : 8'h00);
`else
      n_cmp++; if (SO !== so_pat[7-i]) begin n_err++; $display("FAIL msb_so[%0d] got %b want %b", i, SO, so_pat[7-i]); end
      qm = {qm[6:0], 1'b0};
`endif
      tick();
      if (DONE === 1'b1) pulses++;
      n_cmp++; if (DONE !== (i == 7)) begin n_err++; $display("FAIL msb_done[%0d] got %b want %b", i, DONE, (i == 7)); end
      n_cmp++; if (CNT !== 4'((i + 1) % 8)) begin n_err++; $display("FAIL msb_cnt[%0d] got %0d want %0d", i, CNT, (i + 1) % 8); end
    end
    n_cmp++; if (Q !== qm) begin n_err++; $display("FAIL msb_final_q got %h want %h", Q, qm); end
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL msb_pulses got %0d want 1", pulses); end
    cyc(1'b0, 1'b1, 2'b00, 8'h00, 1'b0);
    n_cmp++; if (DONE !== 1'b0) begin n_err++; $display("FAIL msb_done_clear got %b want 0", DONE); end
    n_cmp++; if (SO !== 1'b0) begin n_err++; $display("FAIL hold_so got %b want 0", SO); end
  endtask

  task automatic test_lsb_shift();
    cyc(1'b0, 1'b1, 2'b01, 8'h01, 1'b0);
    for (int i = 0; i < 8; i++) begin
      set_in(1'b0, 1'b1, 2'b11, 8'h00, 1'b1);
      n_cmp++; if (SO !== (i == 0)) begin n_err++; $display("FAIL lsb_so[%0d] got %b want %b", i, SO, (i == 0)); end
      tick();
      n_cmp++; if (DONE !== (i == 7)) begin n_err++; $display("FAIL lsb_done[%0d] got %b want %b", i, DONE, (i == 7)); end
    end
    n_cmp++; if (Q !== 8'hFF) begin n_err++; $display("FAIL lsb_final_q got %h want ff", Q); end
    n_cmp++; if (CNT !== 4'd0) begin n_err++; $display("FAIL lsb_final_cnt got %0d want 0", CNT); end
  endtask

  task automatic test_enable_stall();
    cyc(1'b0, 1'b1, 2'b01, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 2'b11, 8'h00, 1'b1);
    n_cmp++; if (Q !== 8'hE0) begin n_err++; $display("FAIL stall_pre_q got %h want e0", Q); end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 2'b11, 8'h5A, 1'b0);
      n_cmp++; if (Q !== 8'hE0) begin n_err++; $display("FAIL stall_q[%0d] got %h want e0", i, Q); end
      n_cmp++; if (CNT !== 4'd3) begin n_err++; $display("FAIL stall_cnt[%0d] got %0d want 3", i, CNT); end
      n_cmp++; if (DONE !== 1'b0) begin n_err++; $display("FAIL stall_done[%0d] got %b want 0", i, DONE); end
    end
    cyc(1'b0, 1'b1, 2'b00, 8'h5A, 1'b0);
    n_cmp++; if (Q !== 8'hE0 || CNT !== 4'd3) begin n_err++; $display("FAIL mode_hold got q=%h cnt=%0d want e0/3", Q, CNT); end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 2'b11, 8'h00, 1'b1);
      n_cmp++; if (DONE !== (i == 4)) begin n_err++; $display("FAIL stall_resume_done[%0d] got %b want %b", i, DONE, (i == 4)); end
    end
    n_cmp++; if (Q !== 8'hFF) begin n_err++; $display("FAIL stall_final_q got %h want ff", Q); end
  endtask

  task automatic test_clr_vs_load();
    int pulses;
    pulses = 0;
    cyc(1'b0, 1'b1, 2'b01, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 2'b11, 8'h00, 1'b1);
    cyc(1'b1, 1'b1, 2'b01, 8'h3C, 1'b1);
    n_cmp++; if (Q !== 8'h00) begin n_err++; $display("FAIL clr_load_q got %h want 00", Q); end
    n_cmp++; if (CNT !== 4'd0) begin n_err++; $display("FAIL clr_load_cnt got %0d want 0", CNT); end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 2'b11, 8'h00, 1'b0);
      if (DONE === 1'b1) pulses++;
      n_cmp++; if (DONE !== (i == 7)) begin n_err++; $display("FAIL clr_frame_done[%0d] got %b want %b", i, DONE, (i == 7)); end
    end
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL clr_frame_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_load_abort();
    cyc(1'b0, 1'b1, 2'b01, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 2'b11, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 2'b01, 8'hC3, 1'b0);
    n_cmp++; if (Q !== 8'hC3 || CNT !== 4'd0) begin n_err++; $display("FAIL load_abort got q=%h cnt=%0d want c3/0", Q, CNT); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    cyc(1'b0, 1'b1, 2'b01, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) begin
      // Alternate direction every shift; the frame count must not care.
      cyc(1'b0, 1'b1, (i % 2 == 0) ? 2'b11 : 2'b10, 8'h00, 1'b0);
      if (DONE === 1'b1) pulses++;
      n_cmp++; if (DONE !== (i == 7 || i == 15)) begin n_err++; $display("FAIL b2b_done[%0d] got %b want %b", i, DONE, (i == 7 || i == 15)); end
    end
    n_cmp++; if (pulses != 2) begin n_err++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
  endtask

  task automatic test_crc();
    logic [7:0] bits;
    logic [7:0] exp_q;
    bits = 8'b0000_0001;
`ifdef MB_SHIFT_REG_CRC_EN
    exp_q = 8'h07;
`else
    exp_q = 8'h01;
`endif
    cyc(1'b0, 1'b1, 2'b01, 8'h00, 1'b0);
    for (int i = 7; i >= 0; i--) cyc(1'b0, 1'b1, 2'b10, 8'h00, bits[i]);
    n_cmp++; if (Q !== exp_q) begin n_err++; $display("FAIL crc_q got %h want %h", Q, exp_q); end
    n_cmp++; if (DONE !== 1'b1) begin n_err++; $display("FAIL crc_done got %b want 1", DONE); end
  endtask

  initial begin
    CLR = 1'b0; EN = 1'b0; MODE = 2'b00; D = 8'h00; SI = 1'b0;
    #2;
    test_reset();
    test_msb_shift();
    test_lsb_shift();
    test_enable_stall();
    test_clr_vs_load();
    test_load_abort();
    test_back_to_back();
    test_crc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mb_shift_reg.md
MB_SHIFT_REG -- requirements
Module: mb_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning register width in bits; legal range 2..32.
REQ-002 The block SHALL have parameter INIT, default 0 (WIDTH bits), meaning the value loaded into Q on reset.
REQ-003 The block SHALL have parameter POLY, default 8'h07 (WIDTH bits), meaning the CRC feedback polynomial, used only when the CRC feature is compiled in.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; the clock port is CLK and the reset port is CLR.
REQ-005 Ports SHALL be as follows:
  - CLK  in  1  clock, rising edge active.
  - CLR  in  1  synchronous active-high reset.
  - EN  in  1  cycle enable.
  - MODE  in  2  00 hold, 01 parallel load, 10 shift MSB-first, 11 shift LSB-first.
  - D  in  WIDTH  parallel load data.
  - SI  in  1  serial input bit.
  - Q  out  WIDTH  register contents, registered.
  - SO  out  1  serial output bit, combinational from Q and MODE.
  - CNT  out  $clog2(WIDTH+1)  shifts completed in the current frame, registered.
  - DONE  out  1  one-cycle frame-complete pulse, registered.

Function
REQ-006 All state SHALL update only on the rising edge of CLK; there SHALL be no asynchronous paths into the state.
REQ-007 Priority per edge SHALL be CLR, then EN, then MODE.
REQ-008 When EN=0 the block SHALL hold Q and CNT, and SHALL drive DONE to 0 on the next edge.
REQ-009 MODE=00 with EN=1 SHALL hold Q and CNT, and DONE SHALL be 0 next cycle.
REQ-010 MODE=01 with EN=1 SHALL load Q<=D and clear CNT and DONE to 0, aborting any partial frame.
REQ-011 MODE=10 with EN=1 SHALL shift Q<={Q[WIDTH-2:0],SI}, with SO=Q[WIDTH-1] before the edge.
REQ-012 MODE=11 with EN=1 SHALL shift Q<={SI,Q[WIDTH-1:1]}, with SO=Q[0] before the edge.
REQ-013 SO SHALL be 0 when MODE is 00 or 01.
REQ-014 Each shift edge SHALL increment CNT by 1, regardless of shift direction; a mid-frame direction change SHALL NOT reset CNT.
REQ-015 On the shift edge where CNT=WIDTH-1, CNT SHALL wrap to 0 and DONE SHALL go to 1 for exactly one cycle.
REQ-016 On every other edge DONE SHALL be 0.
REQ-017 Back-to-back frames SHALL be supported with no idle cycle; DONE SHALL pulse once every WIDTH consecutive shifts.
REQ-018 Latency SHALL be one cycle from any input to Q, CNT and DONE, and zero cycles from Q/MODE to SO.

Reset
REQ-019 CLR=1 at a rising edge SHALL set Q=INIT, CNT=0 and DONE=0, regardless of EN, MODE, D or SI.
REQ-020 CLR asserted mid-frame SHALL discard the partial frame; the next shift SHALL be shift 1 of a new frame.
REQ-021 During CLR, SO SHALL follow the combinational rule applied to the reset Q.

Configuration
REQ-022 With macro MB_SHIFT_REG_CRC_EN defined, MODE=10 SHALL compute fb=Q[WIDTH-1]^SI and Q<={Q[WIDTH-2:0],1'b0}^(fb ? POLY : 0), i.e. a serial CRC, MSB-first, no reflection.
REQ-023 With MB_SHIFT_REG_CRC_EN defined, SO in MODE=10 SHALL remain Q[WIDTH-1]; CNT and DONE SHALL behave unchanged.
REQ-024 With MB_SHIFT_REG_CRC_EN undefined, POLY SHALL be ignored, MODE=10 SHALL be the plain shift of REQ-011, and no CRC logic SHALL be synthesised.
REQ-025 MODE=11 SHALL be a plain shift in both builds.

Verification (WIDTH=8, INIT=0, POLY=8'h07)
REQ-026 The bench SHALL cover reset: EN=0, MODE=01, D=FF, CLR=1 for one edge -> Q=00, CNT=0, DONE=0.
REQ-027 The bench SHALL cover MSB-first shift: load A5, then 8 MODE=10 shifts with SI=0 -> SO=1,0,1,0,0,1,0,1; Q=00; DONE=1 only in the cycle after the 8th edge.
REQ-028 The bench SHALL cover LSB-first shift: load 01, then 8 MODE=11 shifts with SI=1 -> first SO=1, then 0s; final Q=FF; CNT returns to 0 with DONE pulsing.
REQ-029 The bench SHALL cover enable stall: 3 shifts, EN=0 for 3 cycles -> Q and CNT frozen at CNT=3, DONE=0; after 5 more shifts DONE=1.
REQ-030 The bench SHALL cover reset versus load: CLR=1 with MODE=01 and D=3C at shift 4 -> Q=00, CNT=0; then 8 shifts give one DONE pulse.
REQ-031 The bench SHALL cover the CRC build: load 00, shift SI bits 0,0,0,0,0,0,0,1 in MODE=10 -> Q=07 with MB_SHIFT_REG_CRC_EN defined, Q=01 without it.
